// File: rtl/device_b_receiver_if.sv
// Device A -> Device B bus handshake plus the local valid/take consumer port.
// The receiver uses the slave side; whoever drives the bus and consumer uses master.
interface device_b_receiver_if #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4
);
  logic                      readyA;
  logic [WORD_W*WORDS-1:0]   in_B;
  logic                      takeB;
  logic                      acceptedB;
  logic [WORD_W-1:0]         out_B;
  logic                      validB;
  logic                      busyB;

  modport master (
    output readyA,
    output in_B,
    output takeB,
    input  acceptedB,
    input  out_B,
    input  validB,
    input  busyB
  );

  modport slave (
    input  readyA,
    input  in_B,
    input  takeB,
    output acceptedB,
    output out_B,
    output validB,
    output busyB
  );
endinterface

// File: rtl/device_b_receiver.sv
// Captures a packed bus word from Device A with a four-phase acknowledge,
// then streams it out least-significant word first over valid/take.
module device_b_receiver #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  device_b_receiver_if.slave  bus
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SEND
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] words [WORDS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              accepted_q;
  logic              valid_q;
  logic              busy_q;
  logic [WORD_W-1:0] out_q;

  assign idx_nxt = idx + 1'b1;

  assign bus.acceptedB = accepted_q;
  assign bus.validB    = valid_q;
  assign bus.busyB     = busy_q;
  assign bus.out_B     = out_q;

  // in_B is only looked at on the IDLE capture edge, so X elsewhere never leaks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      accepted_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= '0;
      for (int i = 0; i < WORDS; i++) begin
        words[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.readyA) begin
            for (int i = 0; i < WORDS; i++) begin
              words[i] <= bus.in_B[i*WORD_W +: WORD_W];
            end
            idx        <= '0;
            accepted_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          if (!bus.readyA) begin
            accepted_q <= 1'b0;
            valid_q    <= 1'b1;
            out_q      <= words[0];
            state      <= SEND;
          end
        end
        SEND: begin
          if (valid_q && bus.takeB) begin
            if (idx == LAST) begin
              valid_q <= 1'b0;
              out_q   <= '0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              idx   <= idx_nxt;
              out_q <= words[idx_nxt];
            end
          end
        end
        default: begin
          state      <= IDLE;
          accepted_q <= 1'b0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
          out_q      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_device_b_receiver.sv
// Directed bench for device_b_receiver: scoreboard of expected words,
// immediate assertions at every comparison point.
module tb_device_b_receiver;

  logic clk;
  logic rst;

  device_b_receiver_if #(.WORD_W(16), .WORDS(4)) bus ();

  device_b_receiver #(.WORD_W(16), .WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [15:0] q [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_words(input logic [63:0] v);
    for (int i = 0; i < 4; i++) begin
      q.push_back(v[i*16 +: 16]);
    end
  endtask

  // raise readyA with v for hold cycles, then drop it; ends with SEND entered
  task automatic send(input logic [63:0] v, input int hold);
    bus.readyA = 1'b1;
    bus.in_B   = v;
    tick();
    chk("acc_rise", {62'd0, bus.acceptedB, bus.busyB}, 64'd3);
    push_words(v);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("acc_hold", {63'd0, bus.acceptedB}, 64'd1);
    end
    bus.readyA = 1'b0;
    bus.in_B   = 'x;
    tick();
    chk("acc_fall_valid", {62'd0, bus.acceptedB, bus.validB}, 64'd1);
  endtask

  task automatic drain(input logic [15:0] pat, input int len,
                       input bit chk_acc);
    logic [15:0] held;
    logic [15:0] exp;
    bit stall;
    stall = 1'b0;
    held  = '0;
    for (int c = 0; c < 64; c++) begin
      if (q.size() == 0 && !bus.validB) break;
      bus.takeB = pat[c % len];
      if (bus.validB) begin
        if (chk_acc) chk("acc_in_send", {63'd0, bus.acceptedB}, 64'd0);
        if (bus.takeB) begin
          exp = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
          chk("word", {48'd0, bus.out_B}, {48'd0, exp});
        end else begin
          held  = bus.out_B;
          stall = 1'b1;
        end
      end
      tick();
      if (stall) begin
        chk("stall_hold", {47'd0, bus.validB, bus.out_B}, {47'd0, 1'b1, held});
        stall = 1'b0;
      end
    end
    bus.takeB = 1'b0;
    chk("drained", {32'd0, 31'(q.size()), bus.validB}, 64'd0);
  endtask

  logic [63:0] vals [10];

  initial begin
    rst        = 1'b0;
    bus.readyA = 1'b0;
    bus.in_B   = '0;
    bus.takeB  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs",
        {44'd0, bus.out_B, bus.acceptedB, bus.validB, bus.busyB, 1'b0},
        64'd0);
    rst = 1'b1;
    tick();

    // basic transfer, takeB tied high
    send(64'h0123_4567_89AB_CDEF, 2);
    drain(16'hFFFF, 16, 1'b0);
    chk("end_idle", {45'd0, bus.out_B, bus.validB, bus.busyB, bus.acceptedB},
        64'd0);

    // stalling consumer
    send(64'h0123_4567_89AB_CDEF, 2);
    drain(16'b1011001, 7, 1'b0);
    chk("stall_idle", {63'd0, bus.busyB}, 64'd0);

    // readyA raised during SEND must wait for the last word
    send(64'h1111_2222_3333_4444, 1);
    bus.readyA = 1'b1;
    bus.in_B   = 64'hFFFF_0000_AAAA_5555;
    drain(16'hFFFF, 16, 1'b1);
    chk("wait_no_acc", {63'd0, bus.acceptedB}, 64'd0);
    tick();
    chk("late_capture", {62'd0, bus.acceptedB, bus.busyB}, 64'd3);
    push_words(64'hFFFF_0000_AAAA_5555);
    bus.readyA = 1'b0;
    bus.in_B   = 'x;
    tick();
    drain(16'hFFFF, 16, 1'b0);

    // asynchronous reset after word 0 taken
    send(64'hDEAD_BEEF_CAFE_F00D, 1);
    bus.takeB = 1'b1;
    chk("pre_rst_w0", {48'd0, bus.out_B}, {48'd0, q.pop_front()});
    tick();
    bus.takeB = 1'b0;
    chk("pre_rst_w1", {48'd0, bus.out_B}, {48'd0, q[0]});
    #2 rst = 1'b0;
    #1;
    chk("async_rst",
        {44'd0, bus.out_B, bus.acceptedB, bus.validB, bus.busyB, 1'b0},
        64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    send(64'h0008_0007_0006_0005, 1);
    drain(16'hFFFF, 16, 1'b0);

    // long readyA with in_B changing each cycle
    for (int i = 0; i < 10; i++) begin
      vals[i] = {$urandom, $urandom};
    end
    bus.readyA = 1'b1;
    bus.in_B   = vals[0];
    tick();
    chk("long_acc0", {63'd0, bus.acceptedB}, 64'd1);
    push_words(vals[0]);
    for (int i = 1; i < 10; i++) begin
      bus.in_B = vals[i];
      tick();
      chk("long_acc", {63'd0, bus.acceptedB}, 64'd1);
    end
    bus.readyA = 1'b0;
    bus.in_B   = 'x;
    tick();
    drain(16'hFFFF, 16, 1'b0);

    // X on in_B while idle, take with nothing valid
    bus.in_B  = 'x;
    bus.takeB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_x",
          {44'd0, bus.out_B, bus.acceptedB, bus.validB, bus.busyB, 1'b0},
          64'd0);
    end
    chk("no_x_out", {63'd0, $isunknown(bus.out_B)}, 64'd0);
    bus.takeB = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
